// File: rtl/universal_mod_counter_if.sv
// Control/status bundle for universal_mod_counter.
// The master drives the count controls; the slave returns the count and flags.
interface universal_mod_counter_if #(
   parameter int N      = 8,
   parameter int STEP_W = 4
);
   logic              syn_clr;
   logic              load;
   logic              en;
   logic              up;
   logic              mode;
   logic [N-1:0]      d;
   logic [STEP_W-1:0] step;
   logic [N-1:0]      limit;
   logic              clr_ovf;
   logic [N-1:0]      q;
   logic              max_tick;
   logic              min_tick;
   logic              wrap_pulse;
   logic              ovf_sticky;

   modport master (
      output syn_clr, load, en, up, mode, d, step, limit, clr_ovf,
      input  q, max_tick, min_tick, wrap_pulse, ovf_sticky
   );

   modport slave (
      input  syn_clr, load, en, up, mode, d, step, limit, clr_ovf,
      output q, max_tick, min_tick, wrap_pulse, ovf_sticky
   );
endinterface

// File: rtl/universal_mod_counter.sv
// Universal modulo counter: runtime limit and step, wrap or saturate mode,
// registered wrap pulse and set-dominant sticky overflow flag.
module universal_mod_counter #(
   parameter int N      = 8,
   parameter int STEP_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   universal_mod_counter_if.slave    bus
);
   logic [N-1:0] q_q, q_d;
   logic         wrap_q, wrap_d;
   logic         ovf_q, ovf_d;

   // All arithmetic is one bit wider than the count so sums never overflow.
   logic [N:0] lim_x, q_x, step_x, s_x, t_x, lim_p1;
   logic       ovf_set;

   // Effective step is clipped to limit, so a step larger than the range
   // still moves at most one full period.
   always_comb begin
      lim_x  = {1'b0, bus.limit};
      q_x    = {1'b0, q_q};
      step_x = {{(N+1-STEP_W){1'b0}}, bus.step};
      s_x    = (step_x > lim_x) ? lim_x : step_x;
      t_x    = q_x + s_x;
      lim_p1 = lim_x + 1'b1;
   end

   // Next-state: priority syn_clr > load > limit-fix > count.
   always_comb begin
      q_d     = q_q;
      wrap_d  = 1'b0;
      ovf_set = 1'b0;
      ovf_d   = ovf_q;
      if (bus.syn_clr) begin
         q_d = '0;
      end else begin
         if (bus.load) begin
            q_d = (bus.d > bus.limit) ? bus.limit : bus.d;
         end else if (q_q > bus.limit) begin
            // Limit was lowered under the count: pull q back into range.
            q_d = bus.limit;
         end else if (bus.en && (s_x != '0)) begin
            if (bus.up) begin
               if (t_x <= lim_x) begin
                  q_d = t_x[N-1:0];
               end else if (!bus.mode) begin
                  q_d     = N'(t_x - lim_p1);
                  wrap_d  = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  q_d     = bus.limit;
                  ovf_set = 1'b1;
               end
            end else begin
               if (s_x <= q_x) begin
                  q_d = N'(q_x - s_x);
               end else if (!bus.mode) begin
                  q_d     = N'(q_x + lim_p1 - s_x);
                  wrap_d  = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  q_d     = '0;
                  ovf_set = 1'b1;
               end
            end
         end
         // Set wins over clear when both happen in the same cycle.
         ovf_d = ovf_set | (ovf_q & ~bus.clr_ovf);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   // Outputs: registered state plus combinational terminal-count ticks.
   always_comb begin
      bus.q          = q_q;
      bus.wrap_pulse = wrap_q;
      bus.ovf_sticky = ovf_q;
      bus.max_tick   = (q_q == bus.limit);
      bus.min_tick   = (q_q == '0);
   end
endmodule

// File: tb/tb_universal_mod_counter.sv
// Scoreboard bench for universal_mod_counter (N=4, STEP_W=3).
module tb_universal_mod_counter;
   localparam int N = 4;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   universal_mod_counter_if #(.N(N), .STEP_W(SW)) bif ();
   universal_mod_counter #(.N(N), .STEP_W(SW)) dut (.clk(clk), .rst(rst), .bus(bif));

   typedef struct { int q; int w; int o; int lim; } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int m_q = 0;
   int m_ovf = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference model: predicts the post-edge state from the current inputs.
   task automatic predict();
      exp_t e;
      int lim, s, nq, nw, no, set;
      lim = int'(bif.limit);
      s   = (int'(bif.step) < lim) ? int'(bif.step) : lim;
      nq = m_q; nw = 0; set = 0;
      if (rst) begin
         nq = 0; no = 0;
      end else if (bif.syn_clr) begin
         nq = 0; no = m_ovf;
      end else begin
         if (bif.load) nq = (int'(bif.d) < lim) ? int'(bif.d) : lim;
         else if (m_q > lim) nq = lim;
         else if (bif.en && s > 0) begin
            if (bif.up) begin
               if (m_q + s <= lim) nq = m_q + s;
               else if (!bif.mode) begin nq = (m_q + s) % (lim + 1); nw = 1; set = 1; end
               else begin nq = lim; set = 1; end
            end else begin
               if (s <= m_q) nq = m_q - s;
               else if (!bif.mode) begin nq = (m_q - s + lim + 1) % (lim + 1); nw = 1; set = 1; end
               else begin nq = 0; set = 1; end
            end
         end
         no = (set != 0 || (m_ovf != 0 && !bif.clr_ovf)) ? 1 : 0;
      end
      e.q = nq; e.w = nw; e.o = no; e.lim = lim;
      sb.push_back(e);
      m_q = nq; m_ovf = no;
   endtask

   // One clock: push the expectation, take the edge, pop and compare.
   task automatic tick();
      exp_t e;
      predict();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("q", int'(bif.q), e.q);
      chk("wrap_pulse", int'(bif.wrap_pulse), e.w);
      chk("ovf_sticky", int'(bif.ovf_sticky), e.o);
      chk("max_tick", int'(bif.max_tick), (e.q == e.lim) ? 1 : 0);
      chk("min_tick", int'(bif.min_tick), (e.q == 0) ? 1 : 0);
   endtask

   task automatic idle();
      rst = 0; bif.syn_clr = 0; bif.load = 0; bif.en = 0; bif.clr_ovf = 0;
   endtask

   initial begin
      rst = 1; bif.syn_clr = 0; bif.load = 0; bif.en = 0; bif.up = 1;
      bif.mode = 0; bif.d = '0; bif.step = '0; bif.limit = '0; bif.clr_ovf = 0;
      tick();

      // 1: reset from mid-count
      idle(); bif.limit = 9; bif.load = 1; bif.d = 9; tick();
      chk("s1_preload", int'(bif.q), 9);
      idle(); rst = 1; bif.en = 1; bif.step = 3; tick();
      chk("s1_rst_q", int'(bif.q), 0);
      chk("s1_rst_min", int'(bif.min_tick), 1);

      // 2: wrap up by 3 over limit 9
      idle(); bif.mode = 0; bif.up = 1; bif.step = 3; bif.en = 1;
      tick(); chk("s2_q3", int'(bif.q), 3);
      tick(); chk("s2_q6", int'(bif.q), 6);
      tick(); chk("s2_q9", int'(bif.q), 9); chk("s2_nowrap", int'(bif.wrap_pulse), 0);
      tick(); chk("s2_q2", int'(bif.q), 2); chk("s2_wrap", int'(bif.wrap_pulse), 1);
      bif.en = 0; tick(); chk("s2_wrap_drop", int'(bif.wrap_pulse), 0);
      chk("s2_ovf", int'(bif.ovf_sticky), 1);

      // 3: saturate down by 4 from 6
      idle(); bif.load = 1; bif.d = 6; tick();
      idle(); bif.mode = 1; bif.up = 0; bif.step = 4; bif.en = 1;
      tick(); chk("s3_q2", int'(bif.q), 2);
      tick(); chk("s3_q0", int'(bif.q), 0);
      bif.clr_ovf = 1; tick(); chk("s3_q0b", int'(bif.q), 0);
      chk("s3_ovf_setdom", int'(bif.ovf_sticky), 1);
      idle(); bif.clr_ovf = 1; tick(); chk("s3_ovf_clr", int'(bif.ovf_sticky), 0);

      // 4: load clipped to limit, then limit lowered with en=0
      idle(); bif.limit = 12; bif.load = 1; bif.d = 15; tick();
      chk("s4_q12", int'(bif.q), 12); chk("s4_max", int'(bif.max_tick), 1);
      idle(); bif.limit = 5; tick(); chk("s4_fix", int'(bif.q), 5);
      chk("s4_ovf", int'(bif.ovf_sticky), 0);

      // 5: clear beats load/en; oversize step clipped to limit
      idle(); bif.limit = 12; bif.load = 1; bif.d = 7; tick();
      idle(); bif.syn_clr = 1; bif.load = 1; bif.en = 1; tick();
      chk("s5_clr", int'(bif.q), 0);
      idle(); bif.limit = 4; bif.load = 1; bif.d = 3; tick();
      idle(); bif.mode = 0; bif.up = 1; bif.step = 7; bif.en = 1; tick();
      chk("s5_q2", int'(bif.q), 2); chk("s5_wrap", int'(bif.wrap_pulse), 1);

      // 6: zero limit pins the count
      idle(); bif.limit = 0; bif.load = 1; bif.d = 0; tick();
      idle(); bif.clr_ovf = 1; tick();
      idle(); bif.en = 1; bif.step = 5;
      for (int i = 0; i < 4; i++) begin
         bif.up = (i < 2);
         tick();
         chk("s6_q", int'(bif.q), 0); chk("s6_max", int'(bif.max_tick), 1);
         chk("s6_wrap", int'(bif.wrap_pulse), 0); chk("s6_ovf", int'(bif.ovf_sticky), 0);
      end

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         rst         = ($urandom_range(0, 49) == 0);
         bif.syn_clr = ($urandom_range(0, 19) == 0);
         bif.load    = ($urandom_range(0, 9) == 0);
         bif.clr_ovf = ($urandom_range(0, 7) == 0);
         bif.en      = ($urandom_range(0, 3) != 0);
         bif.up      = 1'($urandom_range(0, 1));
         bif.mode    = 1'($urandom_range(0, 1));
         bif.d       = N'($urandom_range(0, 15));
         bif.step    = SW'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) bif.limit = N'($urandom_range(0, 15));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
